// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types and helpers for the SIPO deserializer
package sipo_pkg;

  typedef enum logic {
    LSB_FIRST_ORDER = 1'b0,
    MSB_FIRST_ORDER = 1'b1
  } bit_order_e;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// rtl/sipo_shift_core.sv - shift register and frame bit counter
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_d,
  input  logic                     i_en,
  input  logic                     i_clr,
  output logic [WIDTH-1:0]         o_q,
  output logic [cnt_w(WIDTH)-1:0]  o_bit_cnt,
  output logic                     o_done,
  output logic [WIDTH-1:0]         o_next_word
);

  localparam int CW = cnt_w(WIDTH);

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_next_word;
  logic             w_last;

  generate
    if (bit_order_e'(MSB_FIRST) == MSB_FIRST_ORDER) begin : g_msb
      assign w_next_word = {r_q[WIDTH-2:0], i_d};
    end else begin : g_lsb
      assign w_next_word = {i_d, r_q[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // A clr in the same cycle discards the bit, so it can never complete a frame.
  assign o_done      = i_en & ~i_clr & w_last;
  assign o_next_word = w_next_word;
  assign o_q         = r_q;
  assign o_bit_cnt   = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_q   <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      r_q   <= w_next_word;
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - deserializer top: shift core plus valid/ready holding stage
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_d,
  input  logic                     i_en,
  input  logic                     i_clr,
  output logic [WIDTH-1:0]         o_q,
  output logic [cnt_w(WIDTH)-1:0]  o_bit_cnt,
  output logic [WIDTH-1:0]         o_frame_data,
  output logic                     o_frame_valid,
  input  logic                     i_frame_ready,
  output logic                     o_overrun
);

  logic             w_done;
  logic [WIDTH-1:0] w_next_word;
  logic             w_accept;
  logic [WIDTH-1:0] r_frame_data;
  logic             r_frame_valid;
  logic             r_overrun;

  sipo_shift_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_d        (i_d),
    .i_en       (i_en),
    .i_clr      (i_clr),
    .o_q        (o_q),
    .o_bit_cnt  (o_bit_cnt),
    .o_done     (w_done),
    .o_next_word(w_next_word)
  );

  assign w_accept = r_frame_valid & i_frame_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_done) begin
        // A word completing while the old one is still unconsumed is dropped.
        if (!r_frame_valid || w_accept) begin
          r_frame_data  <= w_next_word;
          r_frame_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_accept) begin
        r_frame_valid <= 1'b0;
      end
      if (i_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_frame_data  = r_frame_data;
  assign o_frame_valid = r_frame_valid;
  assign o_overrun     = r_overrun;

endmodule
